// File: rtl/mem_arbiter_ctrl_pkg.sv
// mem_arbiter_ctrl_pkg: FSM states, IO region default and a width helper
// shared by the memory arbiter/controller files.
package mem_arbiter_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] IO_SEL_DEF = 2'b11;

   // index/count width that never collapses to zero bits
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_pick.sv
// mem_arbiter_ctrl_pick: combinational request picker.
// Ports: clk/rst (pointer reg only), req in, take (grant accepted) in,
//   any/gnt (one-hot)/idx out.
// Default: fixed priority, port 0 highest. With MEMCTRL_RR_ARB_EN defined:
//   round-robin search starting at a pointer that moves to winner+1 on take.
module mem_arbiter_ctrl_pick
   import mem_arbiter_ctrl_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int IDX_W   = 1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [N_PORTS-1:0] req,
   input  logic               take,
   output logic               any,
   output logic [N_PORTS-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);

`ifdef MEMCTRL_RR_ARB_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   always_comb begin
      any = 1'b0;
      gnt = '0;
      idx = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (!any && req[(int'(ptr_q) + k) % N_PORTS]) begin
            any = 1'b1;
            idx = IDX_W'((int'(ptr_q) + k) % N_PORTS);
            gnt[(int'(ptr_q) + k) % N_PORTS] = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (take) begin
         ptr_d = IDX_W'((int'(idx) + 1) % N_PORTS);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic unused_rr;
   assign unused_rr = ^{clk, rst, take};

   always_comb begin
      any = 1'b0;
      gnt = '0;
      idx = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (!any && req[k]) begin
            any    = 1'b1;
            idx    = IDX_W'(k);
            gnt[k] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: N-port arbiter serialising loads/stores into byte beats
// on a byte-wide synchronous RAM/IO bus; little-endian read gather.
// Ports: clk, rst (sync, high), rdy (freeze), io_buffer_full (IO store stall),
//   mem_din/mem_dout/mem_a/mem_wr (byte bus), req/we/addr/len/wdata (per port),
//   done (one-hot pulse), rdata (last load, held).
// Option: MEMCTRL_RR_ARB_EN selects round-robin arbitration (in the picker).
module mem_arbiter_ctrl
   import mem_arbiter_ctrl_pkg::*;
#(
   parameter int         N_PORTS   = 2,
   parameter int         ADDR_W    = 32,
   parameter int         MAX_BYTES = 4,
   parameter logic [1:0] IO_SEL    = IO_SEL_DEF,
   localparam int        LEN_W     = clog2_min1(MAX_BYTES),
   localparam int        IDX_W     = clog2_min1(N_PORTS),
   localparam int        DW        = MAX_BYTES * 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       io_buffer_full,
   input  logic [7:0]                 mem_din,
   output logic [7:0]                 mem_dout,
   output logic [ADDR_W-1:0]          mem_a,
   output logic                       mem_wr,
   input  logic [N_PORTS-1:0]         req,
   input  logic [N_PORTS-1:0]         we,
   input  logic [N_PORTS*ADDR_W-1:0]  addr,
   input  logic [N_PORTS*LEN_W-1:0]   len,
   input  logic [N_PORTS*DW-1:0]      wdata,
   output logic [N_PORTS-1:0]         done,
   output logic [DW-1:0]              rdata
);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [IDX_W-1:0]    gidx_q, gidx_d;
   logic [DW-1:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
   logic [7:0]          mem_dout_q, mem_dout_d;
   logic                mem_wr_q, mem_wr_d;
   logic [N_PORTS-1:0]  done_q, done_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic [DW-1:0]       buf_q, buf_d;
   logic                cap_q, cap_d;
   logic [LEN_W-1:0]    cap_idx_q, cap_idx_d;
   logic                last_q, last_d;

   logic                pick_any;
   logic [N_PORTS-1:0]  pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                take;
   logic                io_stall;

   mem_arbiter_ctrl_pick #(
      .N_PORTS (N_PORTS),
      .IDX_W   (IDX_W)
   ) u_pick (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .take (take),
      .any  (pick_any),
      .gnt  (pick_gnt),
      .idx  (pick_idx)
   );

   // Stores into the IO window wait while the UART buffer is full.
   assign io_stall = io_buffer_full && (mem_a_q[17:16] == IO_SEL);

   assign mem_a    = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign mem_wr   = mem_wr_q & rdy & ~io_stall;
   assign done     = done_q & {N_PORTS{rdy}};
   assign rdata    = rdata_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      gidx_d     = gidx_q;
      wdata_d    = wdata_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = mem_wr_q;
      done_d     = done_q;
      rdata_d    = rdata_q;
      buf_d      = buf_q;
      cap_d      = 1'b0;
      cap_idx_d  = cap_idx_q;
      last_d     = last_q;
      take       = 1'b0;

      // RAM data lags its address by one cycle; land it even when frozen.
      if (cap_q) begin
         buf_d[8*int'(cap_idx_q) +: 8] = mem_din;
      end

      if (rdy) begin
         unique case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  take       = 1'b1;
                  gidx_d     = pick_idx;
                  len_d      = len[int'(pick_idx)*LEN_W +: LEN_W];
                  wdata_d    = wdata[int'(pick_idx)*DW +: DW];
                  mem_a_d    = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                  cnt_d      = '0;
                  last_d     = 1'b0;
                  buf_d      = '0;
                  if (we[pick_idx]) begin
                     state_d    = ST_WRITE;
                     mem_wr_d   = 1'b1;
                     mem_dout_d = wdata[int'(pick_idx)*DW +: 8];
                  end else begin
                     state_d  = ST_READ;
                     mem_wr_d = 1'b0;
                  end
               end
            end
            ST_WRITE: begin
               if (!io_stall) begin
                  if (cnt_q == len_q) begin
                     state_d        = ST_DONE;
                     mem_wr_d       = 1'b0;
                     done_d[gidx_q] = 1'b1;
                  end else begin
                     cnt_d      = cnt_q + LEN_W'(1);
                     mem_a_d    = mem_a_q + ADDR_W'(1);
                     mem_dout_d = wdata_q[8*(int'(cnt_q)+1) +: 8];
                  end
               end
            end
            ST_READ: begin
               if (last_q) begin
                  // final byte lands this edge via buf_d
                  state_d        = ST_DONE;
                  rdata_d        = buf_d;
                  done_d[gidx_q] = 1'b1;
               end else begin
                  cap_d     = 1'b1;
                  cap_idx_d = cnt_q;
                  if (cnt_q == len_q) begin
                     last_d = 1'b1;
                  end else begin
                     cnt_d   = cnt_q + LEN_W'(1);
                     mem_a_d = mem_a_q + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               done_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         gidx_q     <= '0;
         wdata_q    <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
         done_q     <= '0;
         rdata_q    <= '0;
         buf_q      <= '0;
         cap_q      <= 1'b0;
         cap_idx_q  <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         gidx_q     <= gidx_d;
         wdata_q    <= wdata_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         buf_q      <= buf_d;
         cap_q      <= cap_d;
         cap_idx_q  <= cap_idx_d;
         last_q     <= last_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: directed plus randomized transfers against a
// timing/data reference model of the byte-serialising memory arbiter.
module tb_mem_arbiter_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        io_buffer_full;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [63:0] addr;
   logic [3:0]  len;
   logic [63:0] wdata;
   logic [1:0]  done;
   logic [31:0] rdata;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   logic [7:0]  ram [0:255];

   mem_arbiter_ctrl #(
      .N_PORTS   (2),
      .ADDR_W    (32),
      .MAX_BYTES (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .io_buffer_full (io_buffer_full),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .req            (req),
      .we             (we),
      .addr           (addr),
      .len            (len),
      .wdata          (wdata),
      .done           (done),
      .rdata          (rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      mem_din <= ram[mem_a[7:0]];
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_win(input int want, input int kind,
                                 input int s, input int n, input int r);
      return (kind == want) && (r >= s) && (r < s + n);
   endfunction

   // One transfer on port p. kind 1 = rdy low, kind 2 = io_buffer_full high,
   // for cycles s..s+n-1 counted from the first cycle after the grant edge.
   // For loads, d is the RAM content read back.
   task automatic xfer(input int p, input bit w, input logic [31:0] a,
                       input int l, input logic [31:0] d, input int kind,
                       input int s, input int n);
      int          t, rel, wk, rk, r, fin;
      int          beat_rel [4];
      bit          got, io_rgn;
      logic [31:0] expd, ba;
      io_rgn = (a[17:16] == 2'b11);
      // a beat goes out in each cycle that is neither frozen nor IO-stalled
      r = 0;
      for (int k = 0; k <= l; k++) begin
         while (in_win(1, kind, s, n, r) ||
                (w && io_rgn && in_win(2, kind, s, n, r))) r++;
         beat_rel[k] = r;
         r++;
      end
      // loads need one more unfrozen cycle for the last byte
      fin = beat_rel[l] + 1;
      if (!w) begin
         while (in_win(1, kind, s, n, fin)) fin++;
         fin++;
      end
      while (in_win(1, kind, s, n, fin)) fin++;
      expd = '0;
      for (int k = 0; k <= l; k++) begin
         expd[8*k +: 8] = d[8*k +: 8];
         if (!w) ram[8'(a + 32'(k))] = d[8*k +: 8];
      end
      req[p]             = 1'b1;
      we[p]              = w;
      addr[32*p +: 32]   = a;
      len[2*p +: 2]      = 2'(l);
      wdata[32*p +: 32]  = d;
      t   = cyc + 1;
      got = 1'b0;
      wk  = 0;
      rk  = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk);
         #1;
         rel            = cyc - t;
         rdy            = !in_win(1, kind, s, n, rel);
         io_buffer_full = in_win(2, kind, s, n, rel);
         addr[32*p +: 32]  = $urandom;
         wdata[32*p +: 32] = $urandom;
         @(negedge clk);
         if (mem_wr) begin
            check("wr_on_store", 64'(w), 64'(1));
            if (wk <= l) begin
               ba = a + 32'(wk);
               check("wr_cycle", 64'(rel), 64'(beat_rel[wk]));
               check("wr_addr", 64'(mem_a), 64'(ba));
               check("wr_data", 64'(mem_dout), 64'(d[8*wk +: 8]));
            end
            wk++;
         end
         if (!w && rk <= l && rel == beat_rel[rk]) begin
            ba = a + 32'(rk);
            check("rd_addr", 64'(mem_a), 64'(ba));
            rk++;
         end
         if (done != 2'b00) begin
            got = 1'b1;
            check("done_port", 64'(done), 64'(2'b01 << p));
            check("done_cycle", 64'(rel), 64'(fin));
            if (!w) check("rdata", 64'(rdata), 64'(expd));
         end
      end
      check("done_seen", 64'(got), 64'(1));
      if (w) check("beat_count", 64'(wk), 64'(l + 1));
      req[p]         = 1'b0;
      rdy            = 1'b1;
      io_buffer_full = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("done_pulse", 64'(done), 64'(0));
   endtask

   initial begin
      int          p, l, kind, s, n, t, d0, d1;
      bit          w;
      logic [31:0] a, d;
      logic [7:0]  b0, b1;

      for (int i = 0; i < 256; i++) ram[i] = 8'(i);
      rst = 1'b1;
      rdy = 1'b1;
      io_buffer_full = 1'b0;
      req = '0;
      we = '0;
      addr = '0;
      len = '0;
      wdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_wr", 64'(mem_wr), 64'(0));
      check("rst_mem_a", 64'(mem_a), 64'(0));
      check("rst_mem_dout", 64'(mem_dout), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      xfer(1, 1'b0, 32'h0000_1000, 3, 32'h4433_2211, 0, 0, 0);
      xfer(0, 1'b1, 32'h0000_2002, 1, 32'h0000_BEEF, 0, 0, 0);
      xfer(0, 1'b1, 32'h0003_0000, 0, 32'h0000_0041, 2, 0, 5);
      xfer(1, 1'b0, 32'h0000_1000, 3, 32'h4433_2211, 1, 2, 3);
      xfer(1, 1'b1, 32'h0002_0010, 3, 32'hCAFE_F00D, 2, 0, 4);
      xfer(0, 1'b0, 32'hFFFF_FFFE, 3, 32'hA1B2_C3D4, 0, 0, 0);
      xfer(0, 1'b0, 32'h0000_0040, 1, 32'h0000_7E5A, 0, 0, 0);

      // both ports load one byte on the same edge
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      ram[8'h50] = b0;
      ram[8'h60] = b1;
      addr = {32'h0000_0060, 32'h0000_0050};
      len  = '0;
      we   = '0;
      req  = 2'b11;
      t  = cyc + 1;
      d0 = -1;
      d1 = -1;
      for (int i = 0; i < 20 && d1 < 0; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (done[0]) begin
            d0 = cyc - t;
            check("arb_rdata0", 64'(rdata), 64'(b0));
            req[0] = 1'b0;
         end
         if (done[1]) begin
            d1 = cyc - t;
            check("arb_rdata1", 64'(rdata), 64'(b1));
            req[1] = 1'b0;
         end
      end
      check("arb_done0_cycle", 64'(d0), 64'(2));
      check("arb_done1_cycle", 64'(d1), 64'(6));
      @(posedge clk);
      #1;

      // reset during beat 1 of a 4-byte store
      req[0] = 1'b1;
      we[0] = 1'b1;
      addr[31:0] = 32'h0000_0080;
      len[1:0] = 2'd3;
      wdata[31:0] = 32'h1234_5678;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      check("rst_beat1_addr", 64'(mem_a), 64'(32'h81));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_abort_wr", 64'(mem_wr), 64'(0));
      check("rst_abort_done", 64'(done), 64'(0));
      check("rst_abort_addr", 64'(mem_a), 64'(0));
      check("rst_abort_rdata", 64'(rdata), 64'(0));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_quiet", 64'({mem_wr, done}), 64'(0));
      end
      xfer(1, 1'b0, 32'h0000_00C0, 2, 32'h0099_8877, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         p = $urandom_range(0, 1);
         w = 1'($urandom_range(0, 1));
         l = $urandom_range(0, 3);
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a[17:16] = 2'b11;
         a[15:0] = 16'($urandom_range(0, 32'hFFF0));
         d = $urandom;
         kind = $urandom_range(0, 2);
         s = $urandom_range(0, l + 2);
         n = $urandom_range(1, 3);
         xfer(p, w, a, l, d, kind, s, n);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
